pipeline_fetch: RTL and testbench

Instruction-fetch stage of the five-stage RISC-V pipeline, the consumer of the 2-bit `PCSrc` redirect code produced in the MEM stage. Holds the architectural PC, drives the instruction-memory request, and loads the IF/ID pipeline register. On a taken branch, `jal` or `jalr` it redirects the PC and squashes the three younger in-flight instructions. It also honours load-use stalls from the hazard unit and wait states from instruction memory.

---
 rtl/pipeline_fetch.sv | 101 ++++++++++
 tb/tb_pipeline_fetch.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_fetch.sv
// Instruction-fetch stage: architectural PC, imem request and the IF/ID register.
// Optional PIPELINE_FETCH_PERF_EN adds redirect_cnt / stall_cnt event counters.
//
// state | meaning
// BOOT  | first cycle after reset, no fetch request, redirects ignored
// RUN   | fetching, one instruction per cycle when memory is ready
// WAIT  | previous fetch stalled by imem_ready=0, request still asserted
module pipeline_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pc_src_mem,
  input  logic [31:0] branch_target_mem,
  input  logic [31:0] jalr_target_mem,
  input  logic        stall_if,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_if_id,
  output logic [31:0] inst_if_id,
  output logic        valid_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem
`ifdef PIPELINE_FETCH_PERF_EN
  ,
  output logic [31:0] redirect_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, WAIT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        redirect;
  logic [31:0] target;

  assign redirect     = (state != BOOT) && (pc_src_mem != 2'b00);
  assign target       = (pc_src_mem == 2'b01) ? branch_target_mem
                                              : {jalr_target_mem[31:1], 1'b0};
  assign flush_id_ex  = redirect;
  assign flush_ex_mem = redirect;
  assign imem_addr    = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      pc_if_id    <= 32'h0;
      inst_if_id  <= NOP_INST;
      valid_if_id <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state    <= RUN;
          imem_req <= 1'b1;
        end
        default: begin
          // Redirect wins over stall and wait; an outstanding WAIT fetch is dropped.
          if (redirect) begin
            pc          <= target;
            inst_if_id  <= NOP_INST;
            valid_if_id <= 1'b0;
            state       <= RUN;
          end else if (!stall_if) begin
            if (imem_ready) begin
              pc          <= pc + 32'd4;
              pc_if_id    <= pc;
              inst_if_id  <= imem_rdata;
              valid_if_id <= 1'b1;
              state       <= RUN;
            end else begin
              inst_if_id  <= NOP_INST;
              valid_if_id <= 1'b0;
              state       <= WAIT;
            end
          end
        end
      endcase
    end
  end

`ifdef PIPELINE_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt <= 32'h0;
      stall_cnt    <= 32'h0;
    end else begin
      if (redirect)
        redirect_cnt <= redirect_cnt + 32'd1;
      if (stall_if || ((state == WAIT) && !redirect))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_fetch.sv
// Bench for pipeline_fetch: directed scenarios plus random redirect/stall/ready
// traffic checked against a cycle-level behavioural model of the fetch stage.
module tb_pipeline_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pc_src_mem = 2'b00;
  logic [31:0] branch_target_mem = 32'h0;
  logic [31:0] jalr_target_mem = 32'h0;
  logic        stall_if = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc_if_id;
  logic [31:0] inst_if_id;
  logic        valid_if_id;
  logic        flush_id_ex;
  logic        flush_ex_mem;
`ifdef PIPELINE_FETCH_PERF_EN
  logic [31:0] redirect_cnt;
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  pipeline_fetch dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc_src_mem        (pc_src_mem),
    .branch_target_mem (branch_target_mem),
    .jalr_target_mem   (jalr_target_mem),
    .stall_if          (stall_if),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ready        (imem_ready),
    .imem_rdata        (imem_rdata),
    .pc_if_id          (pc_if_id),
    .inst_if_id        (inst_if_id),
    .valid_if_id       (valid_if_id),
    .flush_id_ex       (flush_id_ex),
    .flush_ex_mem      (flush_ex_mem)
`ifdef PIPELINE_FETCH_PERF_EN
    ,
    .redirect_cnt      (redirect_cnt),
    .stall_cnt         (stall_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: fetch-stage architectural state
  logic        m_booted, m_wait, m_valid;
  logic [31:0] m_pc, m_if_pc, m_inst, m_rcnt, m_scnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_reset();
    m_booted = 1'b0; m_wait = 1'b0; m_valid = 1'b0;
    m_pc = 32'h0; m_if_pc = 32'h0; m_inst = NOP; m_rcnt = 32'h0; m_scnt = 32'h0;
  endtask

  task automatic check_regs(input string tag);
    check_eq({tag, ".addr"},  imem_addr,   m_pc);
    check_eq({tag, ".req"},   {31'h0, imem_req}, {31'h0, m_booted});
    check_eq({tag, ".pc"},    pc_if_id,    m_if_pc);
    check_eq({tag, ".inst"},  inst_if_id,  m_inst);
    check_eq({tag, ".valid"}, {31'h0, valid_if_id}, {31'h0, m_valid});
`ifdef PIPELINE_FETCH_PERF_EN
    check_eq({tag, ".rcnt"},  redirect_cnt, m_rcnt);
    check_eq({tag, ".scnt"},  stall_cnt,    m_scnt);
`endif
  endtask

  // One clock: drive inputs at negedge, check flushes, advance model at posedge, check registers.
  task automatic step(input logic [1:0] src, input logic [31:0] bt, input logic [31:0] jt,
                      input logic st, input logic rdy);
    logic        redir;
    logic [31:0] tgt, word;
    @(negedge clk);
    pc_src_mem = src; branch_target_mem = bt; jalr_target_mem = jt;
    stall_if = st; imem_ready = rdy;
    imem_rdata = mem_word(imem_addr);
    redir = m_booted && (src != 2'b00);
    tgt   = (src == 2'b01) ? bt : {jt[31:1], 1'b0};
    word  = mem_word(m_pc);
    #1;
    check_eq("flush_id_ex",  {31'h0, flush_id_ex},  {31'h0, redir});
    check_eq("flush_ex_mem", {31'h0, flush_ex_mem}, {31'h0, redir});
    @(posedge clk);
    if (st || (m_wait && !redir)) m_scnt++;
    if (!m_booted) begin
      m_booted = 1'b1;
    end else if (redir) begin
      m_rcnt++;
      m_pc = tgt; m_inst = NOP; m_valid = 1'b0; m_wait = 1'b0;
    end else if (!st) begin
      if (rdy) begin
        m_if_pc = m_pc; m_inst = word; m_valid = 1'b1; m_pc = m_pc + 32'd4; m_wait = 1'b0;
      end else begin
        m_inst = NOP; m_valid = 1'b0; m_wait = 1'b1;
      end
    end
    #1;
    check_regs("step");
  endtask

  initial begin
    logic seen_34;
    model_reset();
    #12;
    check_regs("reset");
    check_eq("reset.flush", {30'h0, flush_id_ex, flush_ex_mem}, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // boot cycle then straight-line fetch 0,4,...,0x14
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    check_eq("boot.req", {31'h0, imem_req}, 32'h1);
    for (int i = 0; i < 6; i++) step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    check_eq("lag.pc_if_id", pc_if_id, 32'h14);
    check_eq("seq.addr", imem_addr, 32'h18);

    // taken branch at PC=0x18
    step(2'b01, 32'h40, 32'h0, 1'b0, 1'b1);
    check_eq("br.addr", imem_addr, 32'h40);
    check_eq("br.valid", {31'h0, valid_if_id}, 32'h0);
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    check_eq("br.pc_if_id", pc_if_id, 32'h40);

    // jalr, codes 10 and 11
    step(2'b10, 32'h0, 32'h101, 1'b0, 1'b1);
    check_eq("jalr10.addr", imem_addr, 32'h100);
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    step(2'b11, 32'h0, 32'h101, 1'b0, 1'b1);
    check_eq("jalr11.addr", imem_addr, 32'h100);

    // 3-cycle stall at 0x20
    step(2'b01, 32'h20, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
    check_eq("stall.addr", imem_addr, 32'h20);
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    check_eq("stall.resume", imem_addr, 32'h24);

    // memory wait at 0x30, redirect to 0x80 in the second wait cycle
    step(2'b01, 32'h30, 32'h0, 1'b0, 1'b1);
    seen_34 = 1'b0;
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    step(2'b01, 32'h80, 32'h0, 1'b0, 1'b0);
    check_eq("wait.addr", imem_addr, 32'h80);
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
      if (valid_if_id && pc_if_id == 32'h34) seen_34 = 1'b1;
    end
    check_eq("wait.no_34", {31'h0, seen_34}, 32'h0);

    // PC wrap
    step(2'b01, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1);
    step(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    check_eq("wrap.addr", imem_addr, 32'h0);

    // asynchronous reset mid-stream under stall
    step(2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
    pc_src_mem = 2'b01; branch_target_mem = 32'h200;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("midrst");
    check_eq("midrst.flush", {30'h0, flush_id_ex, flush_ex_mem}, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // random traffic; redirects are ignored by the model/RTL during BOOT alike
    for (int i = 0; i < 400; i++) begin
      logic [1:0] s;
      s = ($urandom_range(0, 99) < 15) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(s, $urandom, $urandom, ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 70));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
